// File: rtl/run_det_pkg.sv
// run_det_pkg: FSM state encoding and parameter defaults shared by run_detector.
package run_det_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ZERO = 2'd1, RUN = 2'd2, HOLD = 2'd3} state_t;
  localparam int RUN_LEN_DEF = 5;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with sync clear that saturates at MAX; sync active-low reset.
module sat_counter #(
  parameter int          W   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);
  localparam logic [W-1:0] M = W'(MAX);
  logic [W-1:0] r_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clr) r_q <= '0;
    else if (i_inc && r_q != M) r_q <= r_q + 1'b1;
  end
  assign o_q = r_q;
endmodule

// File: rtl/run_detector.sv
// run_detector: flags a run of exactly (mode=0) or at least (mode=1) RUN_LEN ones framed by 0s.
// Optional saturating detection counter on port cnt when DET_COUNT_EN is defined.
module run_detector
  import run_det_pkg::*;
#(
  parameter int RUN_LEN = RUN_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             j,
  input  logic             en,
  input  logic             mode,
  output logic             w
`ifdef DET_COUNT_EN
  ,output logic [CNT_W-1:0] cnt
`endif
);
  localparam int KW = $clog2(RUN_LEN + 1);
  state_t          r_state, w_next;
  logic            r_w;
  logic [KW-1:0]   w_k;
  logic            w_k_max;
  assign w_k_max = w_k == KW'(RUN_LEN);
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE: w_next = j ? IDLE : ZERO;
      ZERO: w_next = j ? RUN : ZERO;
      RUN:  w_next = j ? ((!mode && w_k_max) ? IDLE : RUN) : (w_k_max ? HOLD : ZERO);
      HOLD: w_next = en ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  // k is held at 0 outside RUN, so the ZERO->RUN increment lands on 1
  sat_counter #(.W(KW), .MAX(RUN_LEN)) u_k (
    .i_clk(clk), .i_rst(rst), .i_clr(w_next != RUN), .i_inc(j), .o_q(w_k)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_w     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_w     <= w_next == HOLD;
    end
  end
  assign w = r_w;
`ifdef DET_COUNT_EN
  sat_counter #(.W(CNT_W), .MAX(2 ** CNT_W - 1)) u_cnt (
    .i_clk(clk), .i_rst(rst), .i_clr(1'b0),
    .i_inc(w_next == HOLD && r_state != HOLD), .o_q(cnt)
  );
`endif
endmodule

// File: tb/tb_run_detector.sv
// tb_run_detector: directed self-checking bench; cnt checks active when DET_COUNT_EN is defined.
module tb_run_detector;
  logic clk = 1'b0, rst = 1'b0, j = 1'b0, en = 1'b0, mode = 1'b0;
  logic w5, w1, ws;
  int checks = 0, failures = 0;
`ifdef DET_COUNT_EN
  logic [7:0] c5, c1;
  logic [1:0] cs;
`endif
  always #5 clk = ~clk;

  run_detector u_dut (.clk(clk), .rst(rst), .j(j), .en(en), .mode(mode), .w(w5)
`ifdef DET_COUNT_EN
    , .cnt(c5)
`endif
  );
  run_detector #(.RUN_LEN(5), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .j(j), .en(en), .mode(mode), .w(ws)
`ifdef DET_COUNT_EN
    , .cnt(cs)
`endif
  );
  run_detector #(.RUN_LEN(1)) u_one (.clk(clk), .rst(rst), .j(j), .en(en), .mode(mode), .w(w1)
`ifdef DET_COUNT_EN
    , .cnt(c1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // bits are applied MSB first; w must stay low until the last bit, then equal last_w
  task automatic feed(input logic [15:0] bits, input int n, input bit one, input string tag, input logic last_w);
    for (int i = n - 1; i >= 0; i--) begin
      j = bits[i];
      tick();
      check(tag, one ? w1 : w5, i == 0 ? last_w : 1'b0);
    end
  endtask

  task automatic ack(input bit one, input string tag);
    en = 1'b1;
    tick();
    check(tag, one ? w1 : w5, 1'b0);
    en = 1'b0;
  endtask

  initial begin
    reset_dut();
    check("rst_w5", w5, 0);
    check("rst_w1", w1, 0);
    check("rst_ws", ws, 0);
`ifdef DET_COUNT_EN
    check("rst_cnt", c5, 0);
    check("rst_cnt_sat", cs, 0);
`endif
    feed(16'b0111110, 7, 0, "exact5", 1);
    repeat (10) begin
      j = 1'($urandom_range(0, 1));
      tick();
      check("hold", w5, 1);
    end
    ack(0, "ack1");
    feed(16'b01111110, 8, 0, "long_exact", 0);
    mode = 1'b1;
    feed(16'b01111110, 8, 0, "long_atleast", 1);
    ack(0, "ack2");
    mode = 1'b0;
    feed(16'b011111, 6, 0, "mode_pre", 0);
    mode = 1'b1;
    feed(16'b10, 2, 0, "mode_switch", 1);
    ack(0, "ack3");
    mode = 1'b0;
    reset_dut();
    feed(16'b011110111110, 12, 0, "two_frames", 1);
`ifdef DET_COUNT_EN
    check("two_frames_cnt", c5, 1);
`endif
    ack(0, "ack4");
    feed(16'b0111, 4, 0, "pre_rst", 0);
    j = 1'b1;
    rst = 1'b0;
    tick();
    check("mid_rst_w", w5, 0);
    rst = 1'b1;
    feed(16'b110, 3, 0, "post_rst", 0);
    feed(16'b0111110, 7, 0, "hold_pre_rst", 1);
    rst = 1'b0;
    tick();
    check("hold_rst_w", w5, 0);
    rst = 1'b1;
    en = 1'b1;
    feed(16'b011111, 6, 0, "en_outside", 0);
    en = 1'b0;
    feed(16'b0, 1, 0, "en_outside_end", 1);
    ack(0, "ack5");
    reset_dut();
    for (int n = 1; n <= 5; n++) begin
      feed(16'b0111110, 7, 0, "sat_det", 1);
      check("sat_w", ws, 1);
      ack(0, "sat_ack");
`ifdef DET_COUNT_EN
      check("sat_cnt", cs, n > 3 ? 3 : n);
      check("wide_cnt", c5, n);
`endif
    end
    reset_dut();
    feed(16'b010, 3, 1, "r1_010", 1);
    ack(1, "r1_ack");
    feed(16'b0110, 4, 1, "r1_0110", 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
